// File: rtl/lsu_if.sv
// Memory bus between the load/store unit (master) and the data memory (slave).
// The request fields are held stable by the master until bus_ack completes the access.
interface lsu_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: passes ALU results through, checks alignment and runs one
// memory access at a time with a bounded wait for bus_ack.
module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [1:0]  in_size,
    input  logic        in_signed,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [31:0] in_alu_res,
    input  logic [4:0]  in_rd,
    input  logic        in_w_rd,
    output logic        out_valid,
    output logic [31:0] out_res,
    output logic [4:0]  out_rd,
    output logic        out_w_rd,
    output logic        out_fault,
    lsu_if.master       bus
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          ld_r;
    logic          sgn_r;
    logic [1:0]    size_r;
    logic [1:0]    off_r;
    logic [4:0]    rd_r;
    logic          w_rd_r;
    logic          mem_s;
    logic          fault_s;

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        logic [31:0] d;
        case (size)
            2'd0:    d = {4{wdata[7:0]}};
            2'd1:    d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_lane(input logic [31:0] rdata, input logic [1:0] size,
                                              input logic [1:0] off, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (size)
            2'd0:    r = {{24{sgn & b[7]}}, b};
            2'd1:    r = {{16{sgn & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    // Classify the incoming request; size/alignment only matter for memory operations
    always_comb begin
        mem_s   = in_load | in_store;
        fault_s = 1'b0;
        if (in_load & in_store) begin
            fault_s = 1'b1;
        end else if (mem_s) begin
            case (in_size)
                2'd0:    fault_s = 1'b0;
                2'd1:    fault_s = in_addr[0];
                2'd2:    fault_s = |in_addr[1:0];
                default: fault_s = 1'b1;
            endcase
        end else begin
            fault_s = 1'b0;
        end
    end

    assign in_ready = (state_r == IDLE);

    // Request acceptance, bus access sequencing and write-back result registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= IDLE;
            cnt_r         <= CW'(0);
            ld_r          <= 1'b0;
            sgn_r         <= 1'b0;
            size_r        <= 2'b00;
            off_r         <= 2'b00;
            rd_r          <= 5'd0;
            w_rd_r        <= 1'b0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0;
            bus.bus_be    <= 4'h0;
            bus.bus_wdata <= 32'h0;
            out_valid     <= 1'b0;
            out_res       <= 32'h0;
            out_rd        <= 5'd0;
            out_w_rd      <= 1'b0;
            out_fault     <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid && fault_s) begin
                        out_valid <= 1'b1;
                        out_res   <= in_addr;
                        out_rd    <= in_rd;
                        out_w_rd  <= 1'b0;
                        out_fault <= 1'b1;
                    end else if (in_valid && !mem_s) begin
                        out_valid <= 1'b1;
                        out_res   <= in_alu_res;
                        out_rd    <= in_rd;
                        out_w_rd  <= in_w_rd;
                        out_fault <= 1'b0;
                    end else if (in_valid) begin
                        state_r       <= ACCESS;
                        cnt_r         <= CW'(0);
                        ld_r          <= in_load;
                        sgn_r         <= in_signed;
                        size_r        <= in_size;
                        off_r         <= in_addr[1:0];
                        rd_r          <= in_rd;
                        w_rd_r        <= in_w_rd;
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= in_store;
                        bus.bus_addr  <= {in_addr[31:2], 2'b00};
                        bus.bus_be    <= byte_enable(in_size, in_addr[1:0]);
                        bus.bus_wdata <= store_lanes(in_size, in_wdata);
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    // Acknowledge wins over an expiring wait counter
                    if (bus.bus_ack) begin
                        state_r     <= IDLE;
                        bus.bus_req <= 1'b0;
                        out_valid   <= 1'b1;
                        out_res     <= ld_r ? load_lane(bus.bus_rdata, size_r, off_r, sgn_r) : 32'h0;
                        out_rd      <= rd_r;
                        out_w_rd    <= ld_r & w_rd_r;
                        out_fault   <= 1'b0;
                    end else if (cnt_r == TO_LAST) begin
                        state_r     <= IDLE;
                        bus.bus_req <= 1'b0;
                        out_valid   <= 1'b1;
                        out_res     <= {bus.bus_addr[31:2], off_r};
                        out_rd      <= rd_r;
                        out_w_rd    <= 1'b0;
                        out_fault   <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    bus.bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: vector table plus hand-written multi-cycle
// sequences; write-back results are checked through a scoreboard queue.
module tb_lsu;

    typedef struct {
        logic        ld;
        logic        st;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        w_rd;
        logic [31:0] rdata;
        logic        bus;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] res;
        logic        ow_rd;
        logic        fault;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        w_rd;
        logic        fault;
        logic        chk_res;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_load = 1'b0;
    logic        in_store = 1'b0;
    logic [1:0]  in_size = 2'd0;
    logic        in_signed = 1'b0;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_wdata = 32'h0;
    logic [31:0] in_alu_res = 32'h0;
    logic [4:0]  in_rd = 5'd0;
    logic        in_w_rd = 1'b0;
    logic        out_valid;
    logic [31:0] out_res;
    logic [4:0]  out_rd;
    logic        out_w_rd;
    logic        out_fault;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[16];
    int   nreq;

    lsu_if bif ();

    lsu #(.TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
        .in_size(in_size), .in_signed(in_signed), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_alu_res(in_alu_res), .in_rd(in_rd), .in_w_rd(in_w_rd),
        .out_valid(out_valid), .out_res(out_res), .out_rd(out_rd), .out_w_rd(out_w_rd),
        .out_fault(out_fault), .bus(bif.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest expected result
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_out: got out_valid=1 rd=%0d expected no output", out_rd);
            end else begin
                mon_e = sb_q.pop_front();
                if (mon_e.chk_res) check("sb_out_res", out_res, mon_e.res);
                check("sb_out_rd", {27'd0, out_rd}, {27'd0, mon_e.rd});
                check("sb_out_w_rd", {31'd0, out_w_rd}, {31'd0, mon_e.w_rd});
                check("sb_out_fault", {31'd0, out_fault}, {31'd0, mon_e.fault});
            end
        end
    end

    task automatic drive_req(input logic ld, input logic st, input logic [1:0] size, input logic sgn,
                             input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] alu,
                             input logic [4:0] rd, input logic w_rd);
        in_valid = 1'b1; in_load = ld; in_store = st; in_size = size; in_signed = sgn;
        in_addr = addr; in_wdata = wdata; in_alu_res = alu; in_rd = rd; in_w_rd = w_rd;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        @(negedge clk);
        drive_req(v.ld, v.st, v.size, v.sgn, v.addr, v.wdata, v.alu, v.rd, v.w_rd);
        check("in_ready_idle", {31'd0, in_ready}, 32'd1);
        e.res = v.res; e.rd = v.rd; e.w_rd = v.ow_rd; e.fault = v.fault; e.chk_res = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        idle_inputs();
        if (v.bus) begin
            check("bus_req_on", {31'd0, bif.bus_req}, 32'd1);
            check("bus_we", {31'd0, bif.bus_we}, {31'd0, v.st});
            check("bus_addr", bif.bus_addr, v.baddr);
            check("bus_be", {28'd0, bif.bus_be}, {28'd0, v.be});
            if (v.st) check("bus_wdata", bif.bus_wdata, v.bwdata);
            check("out_valid_early", {31'd0, out_valid}, 32'd0);
            bif.bus_ack = 1'b1;
            bif.bus_rdata = v.rdata;
            @(negedge clk);
            bif.bus_ack = 1'b0;
            check("out_valid_lat2", {31'd0, out_valid}, 32'd1);
            check("bus_req_off", {31'd0, bif.bus_req}, 32'd0);
            check("in_ready_after", {31'd0, in_ready}, 32'd1);
        end else begin
            check("out_valid_lat1", {31'd0, out_valid}, 32'd1);
            check("no_bus_req", {31'd0, bif.bus_req}, 32'd0);
        end
    endtask

    initial begin
        exp_t e;
        bif.bus_ack = 1'b0;
        bif.bus_rdata = 32'h0;

        // ld st size sgn addr wdata alu rd w_rd rdata bus baddr be bwdata res ow_rd fault
        vecs[0]  = '{1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 32'h1234, 5'd5, 1'b1, 32'h0,
                     1'b0, 32'h0, 4'h0, 32'h0, 32'h1234, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 32'h0, 5'd3, 1'b1, 32'h80FF_0000,
                     1'b1, 32'h100, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'hABCD_5678, 32'h0, 5'd7, 1'b1, 32'hDEAD_BEEF,
                     1'b1, 32'h20, 4'b1100, 32'h5678_5678, 32'h0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h6, 32'h0, 32'h0, 5'd9, 1'b1, 32'h0,
                     1'b0, 32'h0, 4'h0, 32'h0, 32'h6, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0, 5'd10, 1'b1, 32'h8001_7FFF,
                     1'b1, 32'h10, 4'b1100, 32'h0, 32'h0000_8001, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h0, 5'd11, 1'b1, 32'h1234_8765,
                     1'b1, 32'h10, 4'b0011, 32'h0, 32'hFFFF_8765, 1'b1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'd2, 1'b1, 32'h200, 32'h0, 32'h0, 5'd12, 1'b1, 32'hCAFE_F00D,
                     1'b1, 32'h200, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'd0, 1'b0, 32'h81, 32'h1234_56A5, 32'h0, 5'd13, 1'b0, 32'h0,
                     1'b1, 32'h80, 4'b0010, 32'hA5A5_A5A5, 32'h0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'd2, 1'b0, 32'h84, 32'h1122_3344, 32'h0, 5'd14, 1'b0, 32'h0,
                     1'b1, 32'h84, 4'b1111, 32'h1122_3344, 32'h0, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'd2, 1'b0, 32'h44, 32'h0, 32'h0, 5'd15, 1'b1, 32'h0,
                     1'b0, 32'h0, 4'h0, 32'h0, 32'h44, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 2'd3, 1'b0, 32'h50, 32'h0, 32'h0, 5'd16, 1'b1, 32'h0,
                     1'b0, 32'h0, 4'h0, 32'h0, 32'h50, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 2'd1, 1'b0, 32'h31, 32'h0, 32'h0, 5'd17, 1'b1, 32'h0,
                     1'b0, 32'h0, 4'h0, 32'h0, 32'h31, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 1'b0, 2'd0, 1'b0, 32'h101, 32'h0, 32'h0, 5'd18, 1'b1, 32'h0000_9A00,
                     1'b1, 32'h100, 4'b0010, 32'h0, 32'h0000_009A, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 1'b0, 2'd0, 1'b1, 32'h102, 32'h0, 32'h0, 5'd19, 1'b1, 32'h007F_0000,
                     1'b1, 32'h100, 4'b0100, 32'h0, 32'h0000_007F, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h0, 5'd20, 1'b0, 32'h0000_0001,
                     1'b1, 32'h8, 4'b1111, 32'h0, 32'h0000_0001, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'hFFFF_0000, 5'd0, 1'b0, 32'h0,
                     1'b0, 32'h0, 4'h0, 32'h0, 32'hFFFF_0000, 1'b0, 1'b0};

        // Reset values
        #12;
        check("rst_bus_req", {31'd0, bif.bus_req}, 32'd0);
        check("rst_bus_we", {31'd0, bif.bus_we}, 32'd0);
        check("rst_bus_addr", bif.bus_addr, 32'h0);
        check("rst_bus_be", {28'd0, bif.bus_be}, 32'h0);
        check("rst_bus_wdata", bif.bus_wdata, 32'h0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_res", out_res, 32'h0);
        check("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check("rst_out_w_rd", {31'd0, out_w_rd}, 32'd0);
        check("rst_out_fault", {31'd0, out_fault}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // bus_ack while idle must not produce output
        @(negedge clk);
        bif.bus_ack = 1'b1;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        check("idle_ack_ready", {31'd0, in_ready}, 32'd1);
        check("idle_ack_no_valid", {31'd0, out_valid}, 32'd0);

        // Timeout: bus_ack held low
        @(negedge clk);
        drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 5'd21, 1'b1);
        e.res = 32'h40; e.rd = 5'd21; e.w_rd = 1'b0; e.fault = 1'b1; e.chk_res = 1'b0;
        sb_q.push_back(e);
        @(negedge clk);
        idle_inputs();
        nreq = 0;
        while (bif.bus_req === 1'b1 && nreq < 20) begin
            nreq++;
            @(negedge clk);
        end
        check("timeout_req_cycles", nreq, 32'd4);
        check("timeout_out_valid", {31'd0, out_valid}, 32'd1);
        check("timeout_fault", {31'd0, out_fault}, 32'd1);
        check("timeout_in_ready", {31'd0, in_ready}, 32'd1);

        // Ack arriving on the last wait cycle completes normally
        @(negedge clk);
        drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 32'h0, 5'd22, 1'b1);
        e.res = 32'h55AA_55AA; e.rd = 5'd22; e.w_rd = 1'b1; e.fault = 1'b0; e.chk_res = 1'b1;
        sb_q.push_back(e);
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        check("prec_bus_req", {31'd0, bif.bus_req}, 32'd1);
        bif.bus_ack = 1'b1;
        bif.bus_rdata = 32'h55AA_55AA;
        @(negedge clk);
        bif.bus_ack = 1'b0;
        check("prec_out_valid", {31'd0, out_valid}, 32'd1);
        check("prec_fault", {31'd0, out_fault}, 32'd0);

        // Reset during the second ACCESS cycle
        @(negedge clk);
        drive_req(1'b1, 1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h0, 5'd23, 1'b1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        check("mid_bus_req_before", {31'd0, bif.bus_req}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_bus_req", {31'd0, bif.bus_req}, 32'd0);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_vec('{1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 32'h77, 5'd24, 1'b1, 32'h0,
                  1'b0, 32'h0, 4'h0, 32'h0, 32'h77, 1'b1, 1'b0});
        run_vec(vecs[1]);

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
